glyph_row_reader: RTL and testbench
===================================

Name: glyph_row_reader

Overview:
- Read-side client of the glyph library port (port B) of the dual-port memory.
- Accepts "glyph id + row" requests from the VGA/tile renderer.
- Issues single-word reads to the 1-cycle-latency glyph RAM, then serializes the 16-bit row bitmap as a pixel stream, MSB first, under valid/ready flow control.
- Never writes glyph memory.

Parameters:
- RAM_WIDTH, 16, glyph row width in bits; also the number of pixels per row.
- RAM_ADDR_BITSB, 10, glyph memory address width.
- ROW_BITS, 4, row index width; 16 rows per glyph.
- GLYPH_BITS, RAM_ADDR_BITSB-ROW_BITS (6), glyph id width; 64 glyphs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_glyph  in  GLYPH_BITS  glyph index.
- req_row  in  ROW_BITS  row within glyph.
- mem_en  out  1  to glyph RAM enB.
- mem_we  out  1  to glyph RAM weB; constant 0.
- mem_addr  out  RAM_ADDR_BITSB  to glyph RAM addrB.
- mem_dout  in  RAM_WIDTH  from glyph RAM doutB; registered, valid the cycle after mem_en.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer takes pixel.
- pix_data  out  1  current pixel (1 = foreground).
- pix_last  out  1  qualifies the final pixel (bit 0) of a row.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Address: mem_addr = {req_glyph, req_row}, latched on request accept.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready.
  - A pixel is transferred on a cycle with pix_valid && pix_ready.
  - pix_data and pix_last are held stable while pix_valid && !pix_ready.
- FSM states: IDLE, READ, CAPTURE, SHIFT.
  - IDLE: req_ready=1. On accept, latch the address and go to READ.
  - READ: mem_en=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: mem_en=0. Load mem_dout into the 16-bit shift register, set the pixel counter to 0, go to SHIFT.
  - SHIFT: pix_valid=1, pix_data = shreg[15]. On each transfer, shift left by one and increment the counter. pix_last=1 when counter==15. A transfer with pix_last returns the FSM to IDLE.
- Latency: accept at cycle N → mem_en at N+1 → first pix_valid at N+3.
- Throughput (no prefetch): 16 pixels plus 3 overhead cycles per row.
- Stalls: pix_ready=0 freezes the shift register and counter indefinitely.
- mem_en is low in every state except READ. mem_we is always 0.
- req_ready is low outside IDLE, so requests arriving mid-row are held off (backpressure), never dropped.
- Reset (any state, including mid-row):
  - Next state is IDLE.
  - Shift register and counter cleared.
  - Outputs: pix_valid=0, pix_data=0, pix_last=0, mem_en=0, mem_addr=0, busy=0, req_ready=1 on the first cycle after reset.
  - The row in progress is discarded, with no partial pix_last.
- Width rules: the counter is ROW-independent, $clog2(RAM_WIDTH) bits (4), and does not wrap past 15 because the FSM exits on it.
- Address boundaries: glyph 63 / row 15 gives mem_addr 1023; glyph 0 / row 0 gives 0.

Optional Feature:
- Macro: GLYPH_ROW_READER_PREFETCH_EN
- Defined:
  - Adds a one-entry next-row buffer. req_ready is also high in SHIFT when the buffer is empty, and the buffered request's RAM read is issued immediately (READ/CAPTURE overlap SHIFT).
  - The prefetched word is loaded into the shift register on the same cycle the pix_last transfer completes.
  - pix_valid stays high with no bubble, so back-to-back rows stream at 16 cycles per row.
  - Reset also clears the buffer.
- Undefined: behaviour exactly as above, with req_ready high only in IDLE.

Test Plan:
- Reset, then preload addr 0x015 = 0xA5C3; request glyph 1, row 5 → mem_addr=0x015 with mem_en for 1 cycle; pixels 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; pix_last only on the 16th; first pix_valid 3 cycles after accept.
- Same request with pix_ready toggling 1,0,0,1… → identical pixel sequence; data held during stalls; no duplicated or skipped bits.
- Request glyph 63, row 15, word 0xFFFF → mem_addr=1023; 16 ones; busy falls the cycle after the pix_last transfer.
- req_valid held high throughout two rows (0x8001 then 0x0000) → second accept only when back in IDLE (prefetch off), or during SHIFT with zero bubble (prefetch on); mem_we never 1.
- Assert reset after 7 pixels of a row → next cycle pix_valid=0, mem_en=0, req_ready=1; a new request returns a full 16-pixel row.
- Idle with req_valid=0 for 100 cycles → mem_en stays 0, pix_valid stays 0, busy stays 0.

Source files
------------

// File: rtl/glyph_row_reader.sv
`default_nettype none
// ============================================================================
// Module   : glyph_row_reader
// Purpose  : Reads one glyph row from the glyph RAM (port B) and streams its
//            pixels MSB first. Define GLYPH_ROW_READER_PREFETCH_EN to add a
//            one-entry next-row buffer for back-to-back rows with no bubble.
// Revision : 1.0  initial release
// ============================================================================
module glyph_row_reader #(
    parameter int RAM_WIDTH      = 16,
    parameter int RAM_ADDR_BITSB = 10,
    parameter int ROW_BITS       = 4,
    parameter int GLYPH_BITS     = RAM_ADDR_BITSB - ROW_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [GLYPH_BITS-1:0]     req_glyph,
    input  logic [ROW_BITS-1:0]       req_row,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [RAM_ADDR_BITSB-1:0] mem_addr,
    input  logic [RAM_WIDTH-1:0]      mem_dout,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      pix_data,
    output logic                      pix_last,
    output logic                      busy
);

    localparam int                  CNT_BITS = $clog2(RAM_WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(RAM_WIDTH - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_SHIFT   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [RAM_WIDTH-1:0]      shreg_q, shreg_d;
    logic [CNT_BITS-1:0]       cnt_q, cnt_d;
    logic [RAM_ADDR_BITSB-1:0] addr_q, addr_d;

`ifdef GLYPH_ROW_READER_PREFETCH_EN
    // Buffered next row: read issued, data on mem_dout, or word held.
    logic                 pf_rd_q, pf_rd_d;
    logic                 pf_cap_q, pf_cap_d;
    logic                 pf_full_q, pf_full_d;
    logic [RAM_WIDTH-1:0] pf_data_q, pf_data_d;
    logic                 pf_empty;

    assign pf_empty = !pf_rd_q && !pf_cap_q && !pf_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_rd_q   <= 1'b0;
            pf_cap_q  <= 1'b0;
            pf_full_q <= 1'b0;
            pf_data_q <= '0;
        end else begin
            pf_rd_q   <= pf_rd_d;
            pf_cap_q  <= pf_cap_d;
            pf_full_q <= pf_full_d;
            pf_data_q <= pf_data_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        pix_valid = 1'b0;
`ifdef GLYPH_ROW_READER_PREFETCH_EN
        pf_rd_d   = 1'b0;
        pf_cap_d  = 1'b0;
        pf_full_d = pf_full_q;
        pf_data_d = pf_data_q;
`endif

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = {req_glyph, req_row};
                    state_d = S_READ;
                end
            end
            S_READ: begin
                mem_en  = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                shreg_d = mem_dout;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            default: begin
                pix_valid = 1'b1;
`ifdef GLYPH_ROW_READER_PREFETCH_EN
                req_ready = pf_empty;
                if (req_valid && pf_empty) begin
                    addr_d  = {req_glyph, req_row};
                    pf_rd_d = 1'b1;
                end
                if (pf_rd_q) begin
                    pf_cap_d = 1'b1;
                end
                if (pf_cap_q) begin
                    pf_full_d = 1'b1;
                    pf_data_d = mem_dout;
                end
`endif
                if (pix_ready) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
`ifdef GLYPH_ROW_READER_PREFETCH_EN
                        // Hand over to the next row wherever its read has got to.
                        if (pf_full_q) begin
                            shreg_d   = pf_data_q;
                            pf_full_d = 1'b0;
                            state_d   = S_SHIFT;
                        end else if (pf_cap_q) begin
                            shreg_d   = mem_dout;
                            pf_full_d = 1'b0;
                            state_d   = S_SHIFT;
                        end else if (pf_rd_q) begin
                            pf_cap_d  = 1'b0;
                            state_d   = S_CAPTURE;
                        end else if (req_valid && pf_empty) begin
                            pf_rd_d   = 1'b0;
                            state_d   = S_READ;
                        end
`endif
                    end
                end
            end
        endcase

`ifdef GLYPH_ROW_READER_PREFETCH_EN
        mem_en = mem_en | pf_rd_q;
`endif
    end

    assign mem_we   = 1'b0;
    assign mem_addr = addr_q;
    assign busy     = (state_q != S_IDLE);
    assign pix_data = (state_q == S_SHIFT) && shreg_q[RAM_WIDTH-1];
    assign pix_last = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_glyph_row_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_row_reader
// Purpose  : Directed self-checking bench for glyph_row_reader with a
//            1-cycle-latency glyph RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_glyph_row_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_glyph = '0;
    logic [3:0]  req_row = '0;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_data;
    logic        pix_last;
    logic        busy;

    logic [15:0] mem [0:1023];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic        we_seen = 1'b0;

    glyph_row_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_glyph (req_glyph),
        .req_row   (req_row),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_dout <= mem[mem_addr];
        if (mem_we !== 1'b0) we_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requests one row and consumes n pixels; optional 1,0,0 ready pattern.
    // With keep set, req_valid stays high after accept with the next request.
    task automatic run_row(input logic [5:0] g, input logic [3:0] r, input logic [15:0] word,
                           input bit stall, input int n, input bit keep,
                           input logic [5:0] ng, input logic [3:0] nr, output int a);
        int guard;
        int k;
        int ph;
        logic rdy;
        req_glyph = g;
        req_row   = r;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("accept_timeout", {31'd0, guard < 100}, 32'd1);
        a = cyc;
        tick();
        if (keep) begin
            req_glyph = ng;
            req_row   = nr;
        end else begin
            req_valid = 1'b0;
        end
        check("read_mem_en", {31'd0, mem_en}, 32'd1);
        check("read_mem_addr", {22'd0, mem_addr}, {22'd0, g, r});
        tick();
        check("capture_mem_en", {31'd0, mem_en}, 32'd0);
        check("capture_pix_valid", {31'd0, pix_valid}, 32'd0);
        guard = 0;
        while (!pix_valid && guard < 10) begin
            tick();
            guard++;
        end
        check("first_pix_latency", cyc - a, 32'd3);
        k = 0;
        ph = 0;
        guard = 0;
        while (k < n && guard < 200) begin
            rdy = stall ? (ph % 3 == 0) : 1'b1;
            ph++;
            pix_ready = rdy;
            check("pix_valid", {31'd0, pix_valid}, 32'd1);
            check("pix_data", {31'd0, pix_data}, {31'd0, word[15-k]});
            check("pix_last", {31'd0, pix_last}, {31'd0, k == 15});
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
            check("mem_en_shift", {31'd0, mem_en}, 32'd0);
            if (rdy) k++;
            tick();
            guard++;
        end
        pix_ready = 1'b0;
        check("row_timeout", {31'd0, guard < 200}, 32'd1);
        if (n == 16) begin
            check("busy_after_last", {31'd0, busy}, 32'd0);
            check("pix_valid_after_last", {31'd0, pix_valid}, 32'd0);
        end
    endtask

    initial begin
        int a1;
        int a2;
        bit en_seen;
        bit pv_seen;
        bit busy_seen;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h015] = 16'hA5C3;
        mem[10'd1023] = 16'hFFFF;
        mem[{6'd2, 4'd0}] = 16'h8001;
        mem[{6'd3, 4'd1}] = 16'h0000;
        mem[{6'd4, 4'd2}] = 16'h1234;

        tick();
        tick();
        reset = 1'b0;
        check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_pix_data", {31'd0, pix_data}, 32'd0);
        check("rst_pix_last", {31'd0, pix_last}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Glyph 1 row 5, free-flowing then stalled consumer.
        run_row(6'd1, 4'd5, 16'hA5C3, 1'b0, 16, 1'b0, 6'd0, 4'd0, a1);
        run_row(6'd1, 4'd5, 16'hA5C3, 1'b1, 16, 1'b0, 6'd0, 4'd0, a1);

        // Top address boundary.
        run_row(6'd63, 4'd15, 16'hFFFF, 1'b0, 16, 1'b0, 6'd0, 4'd0, a1);

        // req_valid held across two rows: second accept only back in IDLE.
        run_row(6'd2, 4'd0, 16'h8001, 1'b0, 16, 1'b1, 6'd3, 4'd1, a1);
        run_row(6'd3, 4'd1, 16'h0000, 1'b0, 16, 1'b0, 6'd0, 4'd0, a2);
        check("row_period", a2 - a1, 32'd19);

        // Reset after 7 pixels discards the row.
        run_row(6'd4, 4'd2, 16'h1234, 1'b0, 7, 1'b0, 6'd0, 4'd0, a1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("midrst_pix_last", {31'd0, pix_last}, 32'd0);
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        run_row(6'd4, 4'd2, 16'h1234, 1'b0, 16, 1'b0, 6'd0, 4'd0, a1);

        // Long idle.
        en_seen = 1'b0;
        pv_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_en) en_seen = 1'b1;
            if (pix_valid) pv_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("idle_mem_en", {31'd0, en_seen}, 32'd0);
        check("idle_pix_valid", {31'd0, pv_seen}, 32'd0);
        check("idle_busy", {31'd0, busy_seen}, 32'd0);
        check("mem_we_never", {31'd0, we_seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
